instr_fetch: RTL and testbench

- Instruction fetch stage sitting directly upstream of the instruction field decoder.
- Holds the program counter and issues one word-aligned request at a time to instruction memory over a req/ready + rvalid interface.
- Presents the returned 32-bit instruction with its PC to the decode stage through a valid/ready output register.
- Supports PC redirect (branch/jump) with flush of the output slot and discard of any stale in-flight response.

---
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage feeding the instruction field decoder. It owns the
// program counter and keeps at most one request outstanding to instruction
// memory. Each returned word is placed, together with its address, in a
// single-entry valid/ready output slot. A redirect loads a new PC, flushes the
// slot and makes sure any response still in flight for the old path is dropped.
//
// Parameters
//   RESET_PC     PC loaded on reset (bits [1:0] must be zero)
//   PC_STEP      increment applied after each delivered instruction
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   redirect_valid one-cycle pulse: load redirect_pc and flush
//   redirect_pc    new fetch address, bits [1:0] forced to zero
//   imem_req       request valid towards instruction memory
//   imem_addr      request address (the current pc)
//   imem_ready     memory accepts the request when imem_req && imem_ready
//   imem_rvalid    response valid, one per accepted request
//   imem_rdata     response instruction word
//   instr_valid    output slot holds an instruction
//   instruction    instruction word to the decoder
//   instr_pc       address of that instruction
//   instr_ready    decoder consumes the slot when instr_valid && instr_ready
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc, req_pc_nxt;
  logic        discard, discard_nxt;
  logic        instr_valid_nxt;
  logic [31:0] instruction_nxt;
  logic [31:0] instr_pc_nxt;
  logic        out_free;
  logic        handshake;
  logic        unused_redirect_bits;

  // The low redirect address bits are architecturally ignored.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // A new request is only offered when the slot is empty or being drained this
  // cycle, so a live response can never land on top of an unconsumed word.
  assign out_free  = !instr_valid || instr_ready;
  assign imem_req  = (state == REQ) && out_free;
  assign imem_addr = pc;
  assign handshake = imem_req && imem_ready;

  // Next-state and datapath decisions. Redirect is applied last so that it
  // overrides both the pc update and the slot contents. A response that comes
  // back in the same cycle as a redirect is simply dropped; one that comes back
  // after a redirect was seen while waiting is dropped via the discard flag.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    req_pc_nxt      = req_pc;
    discard_nxt     = discard;
    instr_valid_nxt = instr_valid;
    instruction_nxt = instruction;
    instr_pc_nxt    = instr_pc;

    if (instr_valid && instr_ready) begin
      instr_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        state_nxt = REQ;
      end

      REQ: begin
        if (handshake) begin
          req_pc_nxt = pc;
          state_nxt  = WAIT;
          if (redirect_valid) begin
            discard_nxt = 1'b1;
          end
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          state_nxt   = REQ;
          discard_nxt = 1'b0;
          if (!discard && !redirect_valid) begin
            instruction_nxt = imem_rdata;
            instr_pc_nxt    = req_pc;
            instr_valid_nxt = 1'b1;
            pc_nxt          = req_pc + PC_STEP;
          end
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_nxt          = {redirect_pc[31:2], 2'b00};
      instr_valid_nxt = 1'b0;
    end
  end

  // State and datapath registers; reset returns everything to a clean start
  // so that a late response after reset release arrives in IDLE or REQ and
  // is ignored there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= 32'h0;
      discard     <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      req_pc      <= req_pc_nxt;
      discard     <= discard_nxt;
      instr_valid <= instr_valid_nxt;
      instruction <= instruction_nxt;
      instr_pc    <= instr_pc_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. A memory responder and a transaction-level reference
// model live in the applyStimulus task: the model tracks the next expected fetch
// address, whether the outstanding request is still wanted, and the expected
// contents of the output slot. Directed steps cover the documented scenarios,
// followed by a randomized phase checked against the same model.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready     = 1'b0;
  logic        imem_rvalid    = 1'b0;
  logic [31:0] imem_rdata     = 32'h0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready    = 1'b0;

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  // Free-running clock and a cycle counter used to schedule memory responses.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Memory responder state: responses scheduled by absolute cycle, tagged
  // with the reset epoch they were requested in.
  int          q_due[$];
  logic [31:0] q_addr[$];
  int          q_epoch[$];
  int          mem_lat  = 1;
  bit          ovr_valid = 1'b0;
  logic [31:0] ovr_data  = 32'h0;

  // Reference model state.
  int          epoch     = 0;
  logic [31:0] m_pc      = RESET_PC;
  bit          m_pending = 1'b0;
  bit          m_live    = 1'b0;
  logic [31:0] m_addr    = 32'h0;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] exp_ipc   = 32'h0;
  int          deliveries = 0;

  // Observations from the most recent cycle, used by directed checks.
  bit          obs_req, obs_hs, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_ipc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9600;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs and the memory
  // response, check the request side, then advance the reference model.
  task automatic applyStimulus(input bit rdy, input bit rv, input logic [31:0] rpc,
                               input bit mready);
    bit          rvalid_now;
    bit          deliver;
    bit          exp_req;
    bit          nv;
    logic [31:0] rdata_now;
    logic [31:0] raddr_now;
    int          rep_now;

    @(negedge clk);
    obs_valid = instr_valid;
    obs_instr = instruction;
    obs_ipc   = instr_pc;
    checkOutput("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("instruction", instruction, exp_instr);
      checkOutput("instr_pc", instr_pc, exp_ipc);
    end

    rvalid_now = 1'b0;
    rdata_now  = $urandom;
    raddr_now  = 32'h0;
    rep_now    = -1;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      rvalid_now = 1'b1;
      void'(q_due.pop_front());
      raddr_now = q_addr.pop_front();
      rep_now   = q_epoch.pop_front();
      rdata_now = ovr_valid ? ovr_data : word(raddr_now);
      ovr_valid = 1'b0;
    end

    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = mready;
    imem_rvalid    = rvalid_now;
    imem_rdata     = rdata_now;
    #1;

    obs_req  = imem_req;
    obs_addr = imem_addr;
    obs_hs   = imem_req && imem_ready;

    // A request is expected whenever nothing is outstanding and the slot can
    // accept the result.
    exp_req = !m_pending && (!exp_valid || rdy);
    checkOutput("imem_req", 32'(obs_req), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", obs_addr, m_pc);

    deliver = 1'b0;
    if (rvalid_now && rep_now == epoch && m_pending) begin
      m_pending = 1'b0;
      if (m_live && !rv) begin
        deliver   = 1'b1;
        m_pc      = m_addr + 32'd4;
      end
    end

    if (obs_hs) begin
      q_due.push_back(cyc + mem_lat);
      q_addr.push_back(obs_addr);
      q_epoch.push_back(epoch);
      m_pending = 1'b1;
      m_addr    = m_pc;
      m_live    = 1'b1;
    end

    if (rv) begin
      m_pc   = {rpc[31:2], 2'b00};
      m_live = 1'b0;
    end

    if (rv)                      nv = 1'b0;
    else if (deliver)            nv = 1'b1;
    else if (exp_valid && rdy)   nv = 1'b0;
    else                         nv = exp_valid;

    @(posedge clk);
    exp_valid = nv;
    if (deliver) begin
      exp_instr = rdata_now;
      exp_ipc   = raddr_now;
      deliveries++;
    end
  endtask

  // Asynchronous reset pulse at a falling edge, held for two cycles; ends at the
  // falling edge where reset is released, leaving the DUT in its IDLE cycle.
  task automatic doReset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    imem_ready     = 1'b0;
    instr_ready    = 1'b0;
    epoch++;
    m_pending = 1'b0;
    m_live    = 1'b0;
    m_pc      = RESET_PC;
    exp_valid = 1'b0;
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_instruction", instruction, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_imem_req", 32'(imem_req), 32'h0);
  endtask

  initial begin
    $display("[TB] instr_fetch bench start");
    doReset();

    // Zero-wait memory with a free decoder: one request every other cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("t1_hs", 32'(obs_hs), 32'h1);
      checkOutput("t1_addr", obs_addr, 32'(i * 4));
      if (i > 0) begin
        checkOutput("t1_valid", 32'(obs_valid), 32'h1);
        checkOutput("t1_ipc", obs_ipc, 32'((i - 1) * 4));
        checkOutput("t1_instr", obs_instr, word(32'((i - 1) * 4)));
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("t1_gap", 32'(obs_req), 32'h0);
    end

    // Decoder stalls with the slot full: no requests, slot holds.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("t2_req", 32'(obs_req), 32'h0);
      checkOutput("t2_ipc", obs_ipc, 32'h8);
      checkOutput("t2_instr", obs_instr, word(32'h8));
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t2_release_hs", 32'(obs_hs), 32'h1);
    checkOutput("t2_release_addr", obs_addr, 32'hC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect while waiting on a slow response; that response is dropped.
    mem_lat = 3;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t3_hs", 32'(obs_hs), 32'h1);
    checkOutput("t3_addr", obs_addr, 32'h10);
    mem_lat   = 1;
    ovr_valid = 1'b1;
    ovr_data  = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b1, 32'h0000_1003, 1'b1);
    checkOutput("t3_wait_req", 32'(obs_req), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t3_flushed", 32'(obs_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t3_dropped", 32'(obs_valid), 32'h0);
    checkOutput("t3_new_hs", 32'(obs_hs), 32'h1);
    checkOutput("t3_new_addr", obs_addr, 32'h1000);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t3_valid", 32'(obs_valid), 32'h1);
    checkOutput("t3_ipc", obs_ipc, 32'h1000);
    checkOutput("t3_instr", obs_instr, word(32'h1000));
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as the handshake at 0x8.
    applyStimulus(1'b1, 1'b1, 32'h0000_0008, 1'b0);
    checkOutput("t4_noaccept", 32'(obs_hs), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    checkOutput("t4_hs", 32'(obs_hs), 32'h1);
    checkOutput("t4_addr", obs_addr, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t4_dropped", 32'(obs_valid), 32'h0);
    checkOutput("t4_new_addr", obs_addr, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect to the top word; the pc wraps to zero afterwards.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("t4_ipc", obs_ipc, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t5_addr", obs_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    mem_lat = 5;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t5_ipc", obs_ipc, 32'hFFFF_FFFC);
    checkOutput("t5_wrap_addr", obs_addr, 32'h0);
    checkOutput("t5_wrap_hs", 32'(obs_hs), 32'h1);

    // Reset while waiting; the stale response arrives after release.
    doReset();
    mem_lat = 1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_first_req", 32'(obs_req), 32'h1);
    checkOutput("t6_first_addr", obs_addr, RESET_PC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_hs", 32'(obs_hs), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_stale_ignored", 32'(obs_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_valid", 32'(obs_valid), 32'h1);
    checkOutput("t6_ipc", obs_ipc, RESET_PC);

    // Randomized traffic against the reference model.
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      mem_lat = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                    $urandom, $urandom_range(0, 3) != 0);
    end
    checkOutput("random_progress", 32'(deliveries > 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
